// File: rtl/brick_pkg.sv
// Shared types and default geometry for the brick playfield tile map.
package brick_pkg;

  localparam int DEF_TILE_SIZE   = 32;
  localparam int DEF_GRID_COLS   = 20;
  localparam int DEF_GRID_ROWS   = 15;
  localparam int DEF_FIELD_X     = 0;
  localparam int DEF_FIELD_Y     = 0;
  localparam int DEF_STRONG_HITS = 4;
  localparam int COORD_W         = 11;

  typedef enum logic [1:0] {
    CELL_EMPTY  = 2'd0,
    CELL_BRICK  = 2'd1,
    CELL_STRONG = 2'd2
  } cell_type_e;

  typedef enum logic [1:0] {
    HIT_NONE      = 2'd0,
    HIT_DAMAGED   = 2'd1,
    HIT_DESTROYED = 2'd2
  } hit_result_e;

  // hits holds remaining hits minus one, so a fresh strong brick stores STRONG_HITS-1
  typedef struct packed {
    cell_type_e kind;
    logic [1:0] hits;
  } cell_t;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_IDLE,
    ST_HIT_RD,
    ST_HIT_WR
  } state_e;

endpackage

// File: rtl/brick_level_rom.sv
// Level layout: row 0 is a full wall with every fourth tile (from col 1) strong,
// row 2 is a full wall of normal bricks; everything else is empty.
module brick_level_rom
  import brick_pkg::*;
#(
  parameter int GRID_COLS = DEF_GRID_COLS,
  parameter int IDX_W     = 9
) (
  input  logic [IDX_W-1:0] index,
  output cell_type_e       cell_type
);

  logic [IDX_W-1:0] row;
  logic [IDX_W-1:0] col;

  assign row = index / IDX_W'(GRID_COLS);
  assign col = index % IDX_W'(GRID_COLS);

  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    cell_type = CELL_EMPTY;
    if (row == IDX_W'(0)) begin
      cell_type = ((col & IDX_W'(3)) == IDX_W'(1)) ? CELL_STRONG : CELL_BRICK;
    end else if (row == IDX_W'(2)) begin
      cell_type = CELL_BRICK;
    end
  end

endmodule

// File: rtl/brick_field_map.sv
// Brick grid tile map: layout load, bullet-hit engine and a registered render
// lookup that feeds the brick / strong-brick bitmap stages.
module brick_field_map
  import brick_pkg::*;
#(
  parameter int TILE_SIZE   = DEF_TILE_SIZE,
  parameter int GRID_COLS   = DEF_GRID_COLS,
  parameter int GRID_ROWS   = DEF_GRID_ROWS,
  parameter int FIELD_X     = DEF_FIELD_X,
  parameter int FIELD_Y     = DEF_FIELD_Y,
  parameter int STRONG_HITS = DEF_STRONG_HITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               levelStart,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic               hitValid,
  input  logic [COORD_W-1:0] hitX,
  input  logic [COORD_W-1:0] hitY,
  output logic               hitReady,
  output logic               hitAck,
  output logic [1:0]         hitResult,
  output logic               brickInside,
  output logic               strongInside,
  output logic [COORD_W-1:0] offsetX,
  output logic [COORD_W-1:0] offsetY,
  output logic [8:0]         bricksLeft,
  output logic               levelClear,
  output logic               loadBusy
);

  localparam int                 TILE_SHIFT = $clog2(TILE_SIZE);
  localparam int                 NUM_CELLS  = GRID_COLS * GRID_ROWS;
  localparam int                 IDX_W      = $clog2(NUM_CELLS);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_CELLS - 1);
  localparam logic [COORD_W-1:0] FIELD_W    = COORD_W'(GRID_COLS * TILE_SIZE);
  localparam logic [COORD_W-1:0] FIELD_H    = COORD_W'(GRID_ROWS * TILE_SIZE);
  localparam logic [COORD_W-1:0] TILE_MASK  = COORD_W'(TILE_SIZE - 1);

  // The extra top bit flags a point left of / above the field origin.
  function automatic logic [COORD_W:0] rel_coord(input logic [COORD_W-1:0] p, input int base);
    return {1'b0, p} - (COORD_W + 1)'(base);
  endfunction

  function automatic logic in_field(input logic [COORD_W:0] rx, input logic [COORD_W:0] ry);
    return !rx[COORD_W] && !ry[COORD_W] &&
           (rx[COORD_W-1:0] < FIELD_W) && (ry[COORD_W-1:0] < FIELD_H);
  endfunction

  function automatic logic [IDX_W-1:0] tile_index(input logic [COORD_W:0] rx, input logic [COORD_W:0] ry);
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
    col = rx[COORD_W-1:0] >> TILE_SHIFT;
    row = ry[COORD_W-1:0] >> TILE_SHIFT;
    return IDX_W'(row * COORD_W'(GRID_COLS) + col);
  endfunction

  state_e             state;
  logic [IDX_W-1:0]   load_idx;
  logic [IDX_W-1:0]   hit_idx;
  logic               hit_outside;
  cell_t              cells [NUM_CELLS];
  cell_type_e         rom_type;
  cell_t              load_cell;
  cell_t              hit_cell;
  cell_t              hit_new;
  hit_result_e        hit_res;
  logic               cell_we;
  logic [IDX_W-1:0]   cell_widx;
  cell_t              cell_wdata;
  logic [COORD_W:0]   r_rel_x, r_rel_y, h_rel_x, h_rel_y;
  logic               r_inside, h_inside;
  logic [IDX_W-1:0]   r_idx, h_idx;
  cell_t              r_cell;

  brick_level_rom #(.GRID_COLS(GRID_COLS), .IDX_W(IDX_W)) u_rom (
    .index     (load_idx),
    .cell_type (rom_type)
  );

  assign load_cell = '{kind: rom_type,
                       hits: (rom_type == CELL_STRONG) ? 2'(STRONG_HITS - 1) : 2'd0};

  assign r_rel_x  = rel_coord(pixelX, FIELD_X);
  assign r_rel_y  = rel_coord(pixelY, FIELD_Y);
  assign h_rel_x  = rel_coord(hitX, FIELD_X);
  assign h_rel_y  = rel_coord(hitY, FIELD_Y);
  assign r_inside = in_field(r_rel_x, r_rel_y);
  assign h_inside = in_field(h_rel_x, h_rel_y);
  assign r_idx    = r_inside ? tile_index(r_rel_x, r_rel_y) : '0;
  assign h_idx    = h_inside ? tile_index(h_rel_x, h_rel_y) : '0;
  assign r_cell   = cells[r_idx];

  always_comb begin
    hit_cell = cells[hit_idx];
    hit_new  = hit_cell;
    hit_res  = HIT_NONE;
    if (!hit_outside && hit_cell.kind != CELL_EMPTY) begin
      if (hit_cell.kind == CELL_STRONG && hit_cell.hits != 2'd0) begin
        hit_new.hits = hit_cell.hits - 2'd1;
        hit_res      = HIT_DAMAGED;
      end else begin
        hit_new = '{kind: CELL_EMPTY, hits: 2'd0};
        hit_res = HIT_DESTROYED;
      end
    end
  end

  // Single write port shared by the layout sweep and the hit engine.
  always_comb begin
    cell_we    = 1'b0;
    cell_widx  = load_idx;
    cell_wdata = load_cell;
    if (!levelStart) begin
      if (state == ST_LOAD) begin
        cell_we = 1'b1;
      end else if (state == ST_HIT_RD && hit_res != HIT_NONE) begin
        cell_we    = 1'b1;
        cell_widx  = hit_idx;
        cell_wdata = hit_new;
      end
    end
  end

  // NOTE: the grid has no reset; every cell is rewritten by the load sweep before use.
  always_ff @(posedge clk) begin
    if (cell_we) cells[cell_widx] <= cell_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_LOAD;
      load_idx    <= '0;
      hit_idx     <= '0;
      hit_outside <= 1'b0;
      bricksLeft  <= '0;
      loadBusy    <= 1'b1;
      hitReady    <= 1'b0;
      hitAck      <= 1'b0;
      hitResult   <= HIT_NONE;
      levelClear  <= 1'b0;
    end else begin
      hitAck     <= 1'b0;
      levelClear <= 1'b0;
      if (levelStart) begin
        state      <= ST_LOAD;
        load_idx   <= '0;
        bricksLeft <= '0;
        loadBusy   <= 1'b1;
        hitReady   <= 1'b0;
      end else begin
        case (state)
          ST_LOAD: begin
            if (rom_type != CELL_EMPTY) bricksLeft <= bricksLeft + 9'd1;
            if (load_idx == LAST_IDX) begin
              state    <= ST_IDLE;
              loadBusy <= 1'b0;
              hitReady <= 1'b1;
            end else begin
              load_idx <= load_idx + IDX_W'(1);
            end
          end
          ST_IDLE: begin
            if (hitValid && hitReady) begin
              hit_idx     <= h_idx;
              hit_outside <= !h_inside;
              hitReady    <= 1'b0;
              state       <= ST_HIT_RD;
            end
          end
          ST_HIT_RD: begin
            hitAck    <= 1'b1;
            hitResult <= hit_res;
            if (hit_res == HIT_DESTROYED) begin
              bricksLeft <= bricksLeft - 9'd1;
              levelClear <= (bricksLeft == 9'd1);
            end
            state <= ST_HIT_WR;
          end
          default: begin
            hitReady <= 1'b1;
            state    <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Render lookup: one register stage between the scan position and the flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brickInside  <= 1'b0;
      strongInside <= 1'b0;
      offsetX      <= '0;
      offsetY      <= '0;
    end else begin
      brickInside  <= r_inside && !loadBusy && (r_cell.kind == CELL_BRICK);
      strongInside <= r_inside && !loadBusy && (r_cell.kind == CELL_STRONG);
      offsetX      <= r_inside ? (r_rel_x[COORD_W-1:0] & TILE_MASK) : '0;
      offsetY      <= r_inside ? (r_rel_y[COORD_W-1:0] & TILE_MASK) : '0;
    end
  end

endmodule

// File: tb/tb_brick_field_map.sv
// Self-checking bench for brick_field_map: scoreboard queues for hit results and
// render lookups, plus a reference grid model of the default level.
module tb_brick_field_map;
  import brick_pkg::*;

  logic        clk = 1'b0;
  logic        reset, levelStart, hitValid;
  logic [10:0] pixelX, pixelY, hitX, hitY;
  logic        hitReady, hitAck, brickInside, strongInside, levelClear, loadBusy;
  logic [1:0]  hitResult;
  logic [10:0] offsetX, offsetY;
  logic [8:0]  bricksLeft;

  brick_field_map dut (
    .clk(clk), .reset(reset), .levelStart(levelStart),
    .pixelX(pixelX), .pixelY(pixelY),
    .hitValid(hitValid), .hitX(hitX), .hitY(hitY),
    .hitReady(hitReady), .hitAck(hitAck), .hitResult(hitResult),
    .brickInside(brickInside), .strongInside(strongInside),
    .offsetX(offsetX), .offsetY(offsetY),
    .bricksLeft(bricksLeft), .levelClear(levelClear), .loadBusy(loadBusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] result;
    int         left;
    logic       clear;
  } hit_exp_t;

  hit_exp_t    hit_q[$];
  logic [23:0] render_q[$];
  int          px_q[$];
  int          py_q[$];
  int          m_kind [300];
  int          m_hits [300];
  int          m_left;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic int layout(input int col, input int row);
    if (row == 0) return (col % 4 == 1) ? 2 : 1;
    if (row == 2) return 1;
    return 0;
  endfunction

  task automatic model_load();
    m_left = 0;
    for (int i = 0; i < 300; i++) begin
      m_kind[i] = layout(i % 20, i / 20);
      m_hits[i] = (m_kind[i] == 2) ? 3 : 0;
      if (m_kind[i] != 0) m_left++;
    end
  endtask

  function automatic logic [23:0] render_exp(input int x, input int y, input bit busy);
    int k;
    if (x >= 640 || y >= 480) return 24'd0;
    k = m_kind[(y / 32) * 20 + (x / 32)];
    return {!busy && k == 1, !busy && k == 2, 11'(x % 32), 11'(y % 32)};
  endfunction

  task automatic model_hit(input int x, input int y, output hit_exp_t e);
    int i;
    e.clear  = 1'b0;
    e.result = 2'd0;
    if (x < 640 && y < 480) begin
      i = (y / 32) * 20 + (x / 32);
      if (m_kind[i] == 2 && m_hits[i] > 0) begin
        m_hits[i]--;
        e.result = 2'd1;
      end else if (m_kind[i] != 0) begin
        m_kind[i] = 0;
        m_hits[i] = 0;
        m_left--;
        e.result = 2'd2;
        e.clear  = (m_left == 0);
      end
    end
    e.left = m_left;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_load(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (loadBusy && n < 1000);
    n_checks++;
    if (n !== 300) $display("FAIL %s load_cycles: got %0d expected 300", name, n);
    else n_pass++;
    model_load();
    n_checks++;
    if ({bricksLeft, hitReady, loadBusy} !== {9'd40, 1'b1, 1'b0})
      $display("FAIL %s after_load: bricksLeft=%0d hitReady=%b loadBusy=%b expected 40/1/0",
               name, bricksLeft, hitReady, loadBusy);
    else n_pass++;
  endtask

  task automatic render_stream(input string name, input bit busy);
    int          n = px_q.size();
    logic [23:0] got, exp;
    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin
        exp = render_q.pop_front();
        got = {brickInside, strongInside, offsetX, offsetY};
        n_checks++;
        if (got !== exp)
          $display("FAIL %s pixel(%0d,%0d): got b=%b s=%b ox=%0d oy=%0d expected b=%b s=%b ox=%0d oy=%0d",
                   name, px_q[i-1], py_q[i-1], got[23], got[22], got[21:11], got[10:0],
                   exp[23], exp[22], exp[21:11], exp[10:0]);
        else n_pass++;
      end
      if (i < n) begin
        pixelX = 11'(px_q[i]);
        pixelY = 11'(py_q[i]);
        render_q.push_back(render_exp(px_q[i], py_q[i], busy));
      end
      tick();
    end
    px_q.delete();
    py_q.delete();
  endtask

  task automatic run_hit(input string name, input int x, input int y);
    hit_exp_t e;
    int       w = 0;
    int       lat = 1;
    while (!hitReady && w < 1000) begin
      tick();
      w++;
    end
    hitX     = 11'(x);
    hitY     = 11'(y);
    hitValid = 1'b1;
    model_hit(x, y, e);
    hit_q.push_back(e);
    tick();
    hitValid = 1'b0;
    while (!hitAck && lat < 10) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat !== 2) $display("FAIL %s ack_latency (%0d,%0d): got %0d expected 2", name, x, y, lat);
    else n_pass++;
    e = hit_q.pop_front();
    if (hitAck) begin
      n_checks++;
      if ({hitResult, bricksLeft, levelClear} !== {e.result, 9'(e.left), e.clear})
        $display("FAIL %s result (%0d,%0d): got res=%0d left=%0d clear=%b expected res=%0d left=%0d clear=%b",
                 name, x, y, hitResult, bricksLeft, levelClear, e.result, e.left, e.clear);
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; levelStart = 1'b0; hitValid = 1'b0;
    pixelX = '0; pixelY = '0; hitX = '0; hitY = '0;
    #12;
    n_checks++;
    if ({hitReady, hitAck, hitResult, brickInside, strongInside, offsetX, offsetY,
         bricksLeft, levelClear, loadBusy} !== {38'd0, 1'b1})
      $display("FAIL reset_values: got rdy=%b ack=%b res=%0d b=%b s=%b left=%0d clr=%b busy=%b expected all 0 busy=1",
               hitReady, hitAck, hitResult, brickInside, strongInside, bricksLeft, levelClear, loadBusy);
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    count_load("reset_release");
  endtask

  task automatic test_render();
    px_q = '{45, 700, 40, 0, 639, 640, 5, 2047, 63, 31};
    py_q = '{70, 10, 5, 0, 479, 0, 40, 2047, 31, 480};
    for (int i = 0; i < 6; i++) begin
      px_q.push_back(int'($urandom_range(0, 800)));
      py_q.push_back(int'($urandom_range(0, 600)));
    end
    render_stream("render", 1'b0);
  endtask

  task automatic test_strong();
    for (int i = 0; i < 4; i++) run_hit("strong", 40, 5);
    n_checks++;
    if (bricksLeft !== 9'd39) $display("FAIL strong_left: got %0d expected 39", bricksLeft);
    else n_pass++;
    run_hit("outside", 700, 10);
    run_hit("empty_cell", 5, 40);
    px_q = '{40};
    py_q = '{5};
    render_stream("strong_gone", 1'b0);
  endtask

  task automatic test_back_to_back();
    hit_exp_t e;
    int       acks = 0;
    int       low = 0;
    hitX = 11'd45; hitY = 11'd70; hitValid = 1'b1;
    model_hit(45, 70, e);
    hit_q.push_back(e);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 3) hitValid = 1'b0;
      if (hitAck) begin
        acks++;
        e = hit_q.pop_front();
        n_checks++;
        if (hitResult !== e.result) $display("FAIL b2b_result: got %0d expected %0d", hitResult, e.result);
        else n_pass++;
      end
      if (!hitReady) low++;
    end
    hit_q.delete();
    n_checks++;
    if (acks !== 1 || low !== 2)
      $display("FAIL b2b_handshake: got acks=%0d ready_low=%0d expected acks=1 ready_low=2", acks, low);
    else n_pass++;
    run_hit("fifth_hit", 40, 5);
  endtask

  task automatic test_clear();
    for (int i = 0; i < 300; i++) begin
      while (m_kind[i] != 0) run_hit("clear", (i % 20) * 32 + 16, (i / 20) * 32 + 16);
    end
    n_checks++;
    if ({bricksLeft, levelClear} !== {9'd0, 1'b0})
      $display("FAIL clear_final: got left=%0d clear=%b expected left=0 clear=0 after pulse", bricksLeft, levelClear);
    else n_pass++;
  endtask

  task automatic test_level_start_hit();
    int n = 0;
    int acks = 0;
    hitX = 11'd0; hitY = 11'd0; hitValid = 1'b1;
    tick();
    hitValid   = 1'b0;
    levelStart = 1'b1;
    tick();
    levelStart = 1'b0;
    n_checks++;
    if ({hitAck, loadBusy, hitReady} !== 3'b010)
      $display("FAIL abort_hit: got ack=%b busy=%b rdy=%b expected 0/1/0", hitAck, loadBusy, hitReady);
    else n_pass++;
    do begin
      tick();
      n++;
      if (hitAck) acks++;
    end while (loadBusy && n < 1000);
    n_checks++;
    if (n !== 300 || acks !== 0)
      $display("FAIL abort_reload: got cycles=%0d acks=%0d expected 300 and 0", n, acks);
    else n_pass++;
    model_load();
    px_q = '{0, 45};
    py_q = '{0, 70};
    render_stream("after_reload", 1'b0);
  endtask

  task automatic test_reset_midload();
    levelStart = 1'b1;
    tick();
    levelStart = 1'b0;
    px_q = '{0, 40};
    py_q = '{0, 5};
    render_stream("during_load", 1'b1);
    for (int i = 0; i < 147; i++) tick();
    reset = 1'b1;
    #2;
    n_checks++;
    if ({hitReady, hitAck, hitResult, brickInside, strongInside, offsetX, offsetY,
         bricksLeft, levelClear, loadBusy} !== {38'd0, 1'b1})
      $display("FAIL midload_reset_values: got rdy=%b ack=%b left=%0d ox=%0d busy=%b expected 0/0/0/0/1",
               hitReady, hitAck, bricksLeft, offsetX, loadBusy);
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    count_load("midload_restart");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_render();
    test_strong();
    test_back_to_back();
    test_clear();
    test_level_start_hit();
    test_reset_midload();
    n_checks++;
    if (hit_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d pending expected 0", hit_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
